// File: rtl/ppi_mode1_handshake.sv
// 8255-style Mode 1 strobed handshake port: one data latch shared by input and output modes.
// Optional macro PPI_STB_SYNC_EN adds a two-flop synchronizer on STB_N/ACK_N ahead of edge detection.
module ppi_mode1_handshake #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DIR,
    input  logic             CPU_RD,
    input  logic             CPU_WR,
    input  logic [WIDTH-1:0] CPU_DIN,
    output logic [WIDTH-1:0] CPU_DOUT,
    input  logic             INTE_SET,
    input  logic             INTE_CLR,
    input  logic             STB_N,
    input  logic             ACK_N,
    input  logic [WIDTH-1:0] PORT_IN,
    output logic [WIDTH-1:0] PORT_OUT,
    output logic             PORT_OE,
    output logic             IBF,
    output logic             OBF_N,
    output logic             INTR
);

    typedef enum logic [1:0] {I_EMPTY, I_STROBED, I_FULL} in_state_e;
    typedef enum logic [1:0] {O_EMPTY, O_FULL, O_ACKED} out_state_e;

    in_state_e        in_state_q, in_state_d;
    out_state_e       out_state_q, out_state_d;
    logic [WIDTH-1:0] latch_q, latch_d;
    logic             inte_q, inte_d;
    logic             intr_q, intr_d;
    logic             ibf_q, ibf_d;
    logic             obf_n_q, obf_n_d;
    logic             dir_q, dir_d;
    logic             oe_q, oe_d;

    // Handshake lines as {STB_N, ACK_N}; sample and history flops idle high.
    logic [1:0] hs_s_q, hs_s_d;
    logic [1:0] hs_h_q, hs_h_d;
    logic [1:0] hs_fall, hs_rise;

`ifdef PPI_STB_SYNC_EN
    logic [1:0] hs_m_q, hs_m_d;

    always_comb begin
        hs_m_d = {STB_N, ACK_N};
        hs_s_d = hs_m_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) hs_m_q <= 2'b11;
        else       hs_m_q <= hs_m_d;
    end
`else
    always_comb begin
        hs_s_d = {STB_N, ACK_N};
    end
`endif

    always_comb begin
        hs_h_d  = hs_s_q;
        hs_fall = hs_h_q & ~hs_s_q;
        hs_rise = ~hs_h_q & hs_s_q;
    end

    logic stb_fall, stb_rise, ack_fall, ack_rise;
    assign stb_fall = hs_fall[1];
    assign stb_rise = hs_rise[1];
    assign ack_fall = hs_fall[0];
    assign ack_rise = hs_rise[0];

    // Next-state for both handshake FSMs, latch, interrupt enable and request.
    always_comb begin
        in_state_d  = in_state_q;
        out_state_d = out_state_q;
        latch_d     = latch_q;
        inte_d      = inte_q;
        intr_d      = intr_q;
        dir_d       = DIR;
        oe_d        = ~DIR;

        if (INTE_CLR)      inte_d = 1'b0;
        else if (INTE_SET) inte_d = 1'b1;

        if (dir_q != DIR) begin
            in_state_d  = I_EMPTY;
            out_state_d = O_EMPTY;
            intr_d      = 1'b0;
        end else if (DIR) begin
            case (in_state_q)
                I_EMPTY: begin
                    if (stb_fall) begin
                        latch_d    = PORT_IN;
                        in_state_d = I_STROBED;
                    end
                end
                I_STROBED: begin
                    // A read empties the buffer before the trailing strobe edge can interrupt.
                    if (CPU_RD) begin
                        in_state_d = I_EMPTY;
                        intr_d     = 1'b0;
                    end else if (stb_rise) begin
                        in_state_d = I_FULL;
                        if (inte_q) intr_d = 1'b1;
                    end
                end
                I_FULL: begin
                    if (CPU_RD) begin
                        in_state_d = I_EMPTY;
                        intr_d     = 1'b0;
                    end
                end
                default: in_state_d = I_EMPTY;
            endcase
        end else begin
            if (CPU_WR) begin
                latch_d     = CPU_DIN;
                intr_d      = 1'b0;
                out_state_d = O_FULL;
            end else begin
                case (out_state_q)
                    O_FULL: begin
                        if (ack_fall) out_state_d = O_ACKED;
                    end
                    O_ACKED: begin
                        if (ack_rise) begin
                            out_state_d = O_EMPTY;
                            if (inte_q) intr_d = 1'b1;
                        end
                    end
                    O_EMPTY: out_state_d = O_EMPTY;
                    default: out_state_d = O_EMPTY;
                endcase
            end
        end

        if (INTE_CLR) intr_d = 1'b0;

        ibf_d   = (in_state_d != I_EMPTY);
        obf_n_d = (out_state_d != O_FULL);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_state_q  <= I_EMPTY;
            out_state_q <= O_EMPTY;
            latch_q     <= '0;
            inte_q      <= 1'b0;
            intr_q      <= 1'b0;
            ibf_q       <= 1'b0;
            obf_n_q     <= 1'b1;
            hs_s_q      <= 2'b11;
            hs_h_q      <= 2'b11;
            // Track DIR through reset so release is not mistaken for a mode change.
            dir_q       <= dir_d;
            oe_q        <= oe_d;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            latch_q     <= latch_d;
            inte_q      <= inte_d;
            intr_q      <= intr_d;
            ibf_q       <= ibf_d;
            obf_n_q     <= obf_n_d;
            hs_s_q      <= hs_s_d;
            hs_h_q      <= hs_h_d;
            dir_q       <= dir_d;
            oe_q        <= oe_d;
        end
    end

    assign CPU_DOUT = latch_q;
    assign PORT_OUT = latch_q;
    assign PORT_OE  = oe_q;
    assign IBF      = ibf_q;
    assign OBF_N    = obf_n_q;
    assign INTR     = intr_q;

endmodule

// File: tb/tb_ppi_mode1_handshake.sv
// Directed bench for ppi_mode1_handshake: input, overrun, output, collisions, DIR toggle, reset mid-op.
module tb_ppi_mode1_handshake;

    localparam int unsigned WIDTH = 8;
`ifdef PPI_STB_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             CLK = 1'b0;
    logic             RESET, DIR, CPU_RD, CPU_WR, INTE_SET, INTE_CLR, STB_N, ACK_N;
    logic [WIDTH-1:0] CPU_DIN, PORT_IN, CPU_DOUT, PORT_OUT;
    logic             PORT_OE, IBF, OBF_N, INTR;

    int checks = 0;
    int errors = 0;

    ppi_mode1_handshake #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RESET(RESET), .DIR(DIR), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR),
        .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT), .INTE_SET(INTE_SET), .INTE_CLR(INTE_CLR),
        .STB_N(STB_N), .ACK_N(ACK_N), .PORT_IN(PORT_IN), .PORT_OUT(PORT_OUT),
        .PORT_OE(PORT_OE), .IBF(IBF), .OBF_N(OBF_N), .INTR(INTR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_rd();
        CPU_RD = 1'b1; tick(1); CPU_RD = 1'b0;
    endtask

    task automatic pulse_wr(input logic [WIDTH-1:0] d);
        CPU_DIN = d; CPU_WR = 1'b1; tick(1); CPU_WR = 1'b0;
    endtask

    task automatic pulse_inte(input logic set, input logic clr);
        INTE_SET = set; INTE_CLR = clr; tick(1); INTE_SET = 1'b0; INTE_CLR = 1'b0;
    endtask

    // Full strobe: low 4 cycles, then high long enough for the rise to be processed.
    task automatic strobe(input logic [WIDTH-1:0] d);
        PORT_IN = d; STB_N = 1'b0; tick(4);
        STB_N = 1'b1; tick(LAT);
    endtask

    initial begin
        RESET = 1'b1; DIR = 1'b1; CPU_RD = 1'b0; CPU_WR = 1'b0; CPU_DIN = '0;
        INTE_SET = 1'b0; INTE_CLR = 1'b0; STB_N = 1'b1; ACK_N = 1'b1; PORT_IN = '0;
        tick(2);
        RESET = 1'b0;
        check("rst_dout",  32'(CPU_DOUT), 32'h0);
        check("rst_pout",  32'(PORT_OUT), 32'h0);
        check("rst_ibf",   32'(IBF),      32'h0);
        check("rst_obfn",  32'(OBF_N),    32'h1);
        check("rst_intr",  32'(INTR),     32'h0);
        check("rst_oe",    32'(PORT_OE),  32'h0);

        // Basic input transfer
        pulse_inte(1'b1, 1'b0);
        PORT_IN = 8'hA5; STB_N = 1'b0;
        tick(LAT - 1);
        check("in_ibf_early", 32'(IBF), 32'h0);
        tick(1);
        check("in_ibf",   32'(IBF),      32'h1);
        check("in_dout",  32'(CPU_DOUT), 32'hA5);
        check("in_intr_low", 32'(INTR),  32'h0);
        tick(4 - LAT);
        STB_N = 1'b1;
        tick(LAT - 1);
        check("in_intr_early", 32'(INTR), 32'h0);
        tick(1);
        check("in_intr",  32'(INTR), 32'h1);
        pulse_rd();
        check("rd_ibf",   32'(IBF),      32'h0);
        check("rd_intr",  32'(INTR),     32'h0);
        check("rd_dout",  32'(CPU_DOUT), 32'hA5);

        // Overrun: second strobe while full must not overwrite
        strobe(8'h11);
        check("ov_first_ibf",  32'(IBF),      32'h1);
        check("ov_first_dout", 32'(CPU_DOUT), 32'h11);
        check("ov_first_intr", 32'(INTR),     32'h1);
        pulse_inte(1'b0, 1'b1);
        check("inte_clr_intr", 32'(INTR), 32'h0);
        check("inte_clr_ibf",  32'(IBF),  32'h1);
        pulse_inte(1'b1, 1'b0);
        strobe(8'h22);
        check("ov_dout", 32'(CPU_DOUT), 32'h11);
        check("ov_intr", 32'(INTR),     32'h0);
        check("ov_ibf",  32'(IBF),      32'h1);
        pulse_rd();
        check("ov_rd_ibf", 32'(IBF), 32'h0);

        // Simultaneous set+clear leaves INTE off: transfer raises no INTR
        pulse_inte(1'b1, 1'b1);
        strobe(8'h5A);
        check("setclr_dout", 32'(CPU_DOUT), 32'h5A);
        check("setclr_intr", 32'(INTR),     32'h0);
        pulse_rd();
        pulse_inte(1'b1, 1'b0);

        // Output mode
        DIR = 1'b0; tick(1);
        check("out_oe",   32'(PORT_OE), 32'h1);
        check("out_obfn0", 32'(OBF_N),  32'h1);
        pulse_wr(8'h3C);
        check("wr_pout", 32'(PORT_OUT), 32'h3C);
        check("wr_obfn", 32'(OBF_N),    32'h0);
        CPU_WR = 1'b1; CPU_DIN = 8'h3C; DIR = 1'b0; CPU_WR = 1'b0;
        ACK_N = 1'b0;
        tick(LAT - 1);
        check("ack_obfn_early", 32'(OBF_N), 32'h0);
        tick(1);
        check("ack_obfn", 32'(OBF_N), 32'h1);
        check("ack_intr_low", 32'(INTR), 32'h0);
        ACK_N = 1'b1;
        tick(LAT - 1);
        check("ack_intr_early", 32'(INTR), 32'h0);
        tick(1);
        check("ack_intr", 32'(INTR), 32'h1);
        pulse_wr(8'h77);
        check("wr2_intr", 32'(INTR),     32'h0);
        check("wr2_obfn", 32'(OBF_N),    32'h0);
        check("wr2_pout", 32'(PORT_OUT), 32'h77);
        pulse_rd();
        check("rd_out_obfn", 32'(OBF_N),    32'h0);
        check("rd_out_dout", 32'(CPU_DOUT), 32'h77);

        // CPU_WR coincident with detected ACK rise in O_ACKED
        ACK_N = 1'b0; tick(LAT);
        check("col_acked_obfn", 32'(OBF_N), 32'h1);
        ACK_N = 1'b1; tick(LAT - 1);
        pulse_wr(8'h99);
        check("col_obfn", 32'(OBF_N),    32'h0);
        check("col_intr", 32'(INTR),     32'h0);
        check("col_pout", 32'(PORT_OUT), 32'h99);
        tick(2);
        check("col_intr_later", 32'(INTR), 32'h0);

        // DIR toggle from O_FULL
        DIR = 1'b1; tick(1);
        check("dir_obfn", 32'(OBF_N),    32'h1);
        check("dir_intr", 32'(INTR),     32'h0);
        check("dir_oe",   32'(PORT_OE),  32'h0);
        check("dir_ibf",  32'(IBF),      32'h0);
        check("dir_latch", 32'(PORT_OUT), 32'h99);

        // Reset in I_FULL with INTR pending, strobe held low through release
        strobe(8'h44);
        check("pre_rst_intr", 32'(INTR),     32'h1);
        check("pre_rst_dout", 32'(CPU_DOUT), 32'h44);
        RESET = 1'b1; STB_N = 1'b0; PORT_IN = 8'h66; CPU_RD = 1'b0;
        tick(1);
        check("mid_rst_dout", 32'(CPU_DOUT), 32'h0);
        check("mid_rst_ibf",  32'(IBF),      32'h0);
        check("mid_rst_intr", 32'(INTR),     32'h0);
        check("mid_rst_obfn", 32'(OBF_N),    32'h1);
        tick(1);
        RESET = 1'b0;
        tick(LAT - 1);
        check("rel_ibf_early", 32'(IBF), 32'h0);
        tick(1);
        check("rel_ibf",  32'(IBF),      32'h1);
        check("rel_dout", 32'(CPU_DOUT), 32'h66);
        STB_N = 1'b1; tick(LAT + 1);
        check("rel_intr_inte_off", 32'(INTR), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
